tea_decrypt_iterative: RTL

Iterative TEA decryptor. It is the inverse of the team's iterative TEA encryptor and uses the same AXI-Stream style interfaces.
- Accepts one 64-bit ciphertext block plus a 128-bit key, runs ROUNDS Feistel cycles (one cycle per clock), and emits the 64-bit plaintext.
- Sits on the receive side of the crypto datapath and is exercised in loopback against the encryptor.

---
 rtl/tea_decrypt_iterative.sv | 116 +++++++++++
 1 files changed

// File: rtl/tea_decrypt_iterative.sv
// Iterative TEA decryptor: one TEA cycle (two half-rounds) per clock,
// AXI-Stream style input and output handshakes, one block in flight.
module tea_decrypt_iterative #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [63:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Decryption walks the key schedule backwards from DELTA*ROUNDS.
  localparam logic [31:0] SumInit  = DELTA * 32'(ROUNDS);
  localparam logic [7:0]  LastCnt  = 8'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [31:0]  v0_q, v0_d, v1_q, v1_d;
  logic [31:0]  sum_q, sum_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [63:0]  out_q, out_d;
  logic         valid_q, valid_d;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  v1_rnd, v0_rnd;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // One TEA cycle in reverse; the v0 half uses the freshly updated v1.
  always_comb begin
    v1_rnd = v1_q - (((v0_q << 4) + k2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + k3));
    v0_rnd = v0_q - (((v1_rnd << 4) + k0) ^ (v1_rnd + sum_q) ^ ((v1_rnd >> 5) + k1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          v0_d    = s_axis_tdata[63:32];
          v1_d    = s_axis_tdata[31:0];
          key_d   = key;
          sum_d   = SumInit;
          cnt_d   = 8'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        v0_d  = v0_rnd;
        v1_d  = v1_rnd;
        sum_d = sum_q - DELTA;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastCnt) begin
          out_d   = {v0_rnd, v1_rnd};
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // Output data is left in place after the handshake.
        if (m_axis_tready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign s_axis_tready = (state_q == StIdle);
  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = valid_q;

endmodule
